// File: rtl/add_top.sv
// add_top: signed ripple-carry adder/subtractor with registered result and overflow flag.
// Optional macro ADD_TOP_SATURATE_EN clamps the result to the signed range on overflow.

// add_top_fa: 1-bit full adder stage of the ripple chain
module add_top_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module add_top #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             overflow
);
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] s;
    logic [WIDTH:0]   c;
    logic             ovf;
    logic [WIDTH-1:0] out_d, out_q;
    logic             overflow_d, overflow_q;

    assign bx   = b ^ {WIDTH{cin}};
    assign c[0] = cin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            add_top_fa u_fa (
                .a (a[i]),
                .b (bx[i]),
                .ci(c[i]),
                .s (s[i]),
                .co(c[i+1])
            );
        end
    endgenerate

    assign ovf = c[WIDTH] ^ c[WIDTH-1];

`ifdef ADD_TOP_SATURATE_EN
    // On overflow the true result has the sign of a, so clamp towards that end of the range
    always_comb begin
        overflow_d = ovf;
        out_d      = ovf ? (a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : s;
    end
`else
    // Wrapping build: the modulo-2^WIDTH sum passes straight through
    always_comb begin
        overflow_d = ovf;
        out_d      = s;
    end
`endif

    // Output register with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            overflow_q <= overflow_d;
        end
    end

    assign out      = out_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_add_top.sv
// tb_add_top: self-checking bench for add_top against an integer reference model.
module tb_add_top;
    localparam int W   = 6;
    localparam int MAX = (1 << (W - 1)) - 1;
    localparam int MIN = -(1 << (W - 1));

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cin = 1'b0;
    logic [W-1:0] a   = '0;
    logic [W-1:0] b   = '0;
    logic [W-1:0] out;
    logic         overflow;

    int n_vec = 0;
    int n_err = 0;

    add_top #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .cin     (cin),
        .a       (a),
        .b       (b),
        .out     (out),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic c, input int x, input int y, output logic [W-1:0] o, output logic v);
        int r;
        r = c ? x - y : x + y;
        v = (r > MAX) || (r < MIN);
`ifdef ADD_TOP_SATURATE_EN
        if (v) r = (r > 0) ? MAX : MIN;
`endif
        o = r[W-1:0];
    endtask

    task automatic apply(input logic c, input int x, input int y, input string tag);
        logic [W-1:0] eo;
        logic         ev;
        model(c, x, y, eo, ev);
        cin = c;
        a   = x[W-1:0];
        b   = y[W-1:0];
        @(posedge clk);
        #1;
        check({tag, ".out"}, {26'b0, out}, {26'b0, eo});
        check({tag, ".ovf"}, {31'b0, overflow}, {31'b0, ev});
    endtask

    initial begin
        logic [W-1:0] eo;
        logic         ev;
        #1;
        check("rst0.out", {26'b0, out}, 32'd0);
        check("rst0.ovf", {31'b0, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply(0, 12, -5, "add_12_m5");
        apply(0, -32, 31, "add_m32_31");
        apply(0, 31, 1, "add_31_1");
        apply(0, -32, -1, "add_m32_m1");
        apply(0, -32, -32, "add_m32_m32");
        apply(0, 31, 31, "add_31_31");
        apply(1, 5, 9, "sub_5_9");
        apply(1, 0, -32, "sub_0_m32");
        apply(1, -1, -32, "sub_m1_m32");
        apply(1, 31, -32, "sub_31_m32");
        apply(0, -32, -19, "pre_rst");
        #3;
        rst = 1'b1;
        #1;
        check("rst_async.out", {26'b0, out}, 32'd0);
        check("rst_async.ovf", {31'b0, overflow}, 32'd0);
        a = 6'd31;
        b = 6'd31;
        @(posedge clk);
        #1;
        check("rst_hold.out", {26'b0, out}, 32'd0);
        check("rst_hold.ovf", {31'b0, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply(0, 3, 4, "post_rst");
        for (int c = 0; c < 2; c++)
            for (int x = MIN; x <= MAX; x++)
                for (int y = MIN; y <= MAX; y++)
                    apply(c[0], x, y, c[0] ? "sweep_sub" : "sweep_add");
        for (int k = 0; k < 500; k++)
            apply($urandom_range(0, 1), int'($urandom_range(0, 63)) + MIN, int'($urandom_range(0, 63)) + MIN, "rand");
        model(0, 7, 7, eo, ev);
        cin = 1'b0;
        a   = 6'd7;
        b   = 6'd7;
        @(negedge clk);
        b = 6'd20;
        #2;
        b = 6'd7;
        @(posedge clk);
        #1;
        check("glitch.out", {26'b0, out}, {26'b0, eo});
        check("glitch.ovf", {31'b0, overflow}, {31'b0, ev});
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/add_top.md
Name: add_top

Overview:
- Parameterised signed two's-complement adder/subtractor with signed-overflow detection.
- Sits in the datapath ALU as the add/sub primitive. `cin` selects the operation: 0 = ADD, 1 = SUB.
- The arithmetic core is a structural ripple-carry chain of full adders. Result and overflow flag are registered, giving a fixed 1-cycle latency.

Parameters:
- WIDTH, 6, operand/result width in bits; signed range -(2^(WIDTH-1)) .. 2^(WIDTH-1)-1 (default -32..31).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- cin  input  1  operation select / carry-in: 0 = a+b, 1 = a-b.
- a  input  WIDTH  signed operand A.
- b  input  WIDTH  signed operand B.
- out  output  WIDTH  signed result, registered.
- overflow  output  1  signed-overflow flag for `out`, registered.

Behaviour:
- Reset:
  - rst high asynchronously forces out = 0 and overflow = 0, regardless of clk.
  - Both outputs hold those values while rst is high.
  - First capture happens on the first rising clk edge after rst deasserts.
  - Asserting rst mid-stream discards any pending result immediately.
- Core (combinational):
  - bx[i] = b[i] XOR cin.
  - WIDTH-stage ripple chain: s[i] = a[i]^bx[i]^c[i]; c[i+1] = majority(a[i], bx[i], c[i]); c[0] = cin.
  - Each stage is an instantiated 1-bit full-adder submodule.
- Overflow:
  - ovf = c[WIDTH] XOR c[WIDTH-1].
  - Equivalently: set when a and bx share a sign and s differs from it.
  - Carry-out is never an overflow indicator by itself.
- Register: on each rising clk edge (rst low), out <= s and overflow <= ovf. Latency exactly 1 cycle, throughput 1 per cycle, no handshake.
- Arithmetic rules:
  - out is the exact result modulo 2^WIDTH; wraps on overflow (default build).
  - overflow = 1 iff the mathematical result a±b lies outside [-(2^(WIDTH-1)), 2^(WIDTH-1)-1].
- Boundary cases:
  - Subtracting the most-negative value: a - (-32) with a >= 0 overflows; with a < 0 it does not.
  - -32 + -32 → out = 0, overflow = 1.
  - 31 + 31 → out = -2, overflow = 1.
  - -32 + 31 → -1, overflow = 0.
- Inputs are sampled only at the clock edge; input glitches between edges have no effect.
- X on inputs propagates to outputs. No internal X-masking.

Optional Feature:
- Macro ADD_TOP_SATURATE_EN.
- Defined:
  - On overflow, out is clamped to 2^(WIDTH-1)-1 when the true result is positive, or -(2^(WIDTH-1)) when negative.
  - Sign of the true result = sign of a at overflow.
  - overflow is still asserted; non-overflow results are unchanged.
- Undefined: out wraps modulo 2^WIDTH as described in Behaviour. No saturation logic is synthesised.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with prior out = 13, overflow = 1 -> out = 0 and overflow = 0 immediately, before the next clk edge; both stay 0 until first edge after release.
- Add in range: cin=0, a=12, b=-5 -> one cycle later out = 7, overflow = 0; also a=-32, b=31 -> out = -1, overflow = 0.
- Add overflow: cin=0, a=31, b=1 -> overflow = 1, out = -32 (wrap build) or 31 (ADD_TOP_SATURATE_EN); a=-32, b=-1 -> overflow = 1, out = 31 (wrap) or -32 (saturate).
- Subtract: cin=1, a=5, b=9 -> out = -4, overflow = 0; a=0, b=-32 -> overflow = 1; a=-1, b=-32 -> out = 31, overflow = 0.
- Exhaustive sweep: cin=0 and cin=1, all a, b in -32..31, one operation per clock -> each out/overflow pair matches the integer reference exactly, one cycle after its inputs.
- Back-to-back: change a, b every cycle -> output stream equals input stream delayed by exactly 1 cycle, no bubbles.
